gmii_rx_interface: RTL and testbench



---
 rtl/gmii_pkg.sv | 27 ++
 rtl/crc32_byte.sv | 27 ++
 rtl/gmii_rx_interface.sv | 214 +++++++++++++++++++++
 tb/tb_gmii_rx_interface.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_pkg.sv
// Shared definitions for the GMII receive path: FSM encoding, framing bytes, CRC constants, status bits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package gmii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // Reflected CRC-32; the residue is what the register holds after running over a frame plus its own FCS
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    // status_err bit positions
    localparam int ERR_RX_ER = 0;
    localparam int ERR_FULL  = 1;
    localparam int ERR_OVER  = 2;
    localparam int ERR_FCS   = 3;

endpackage

// File: rtl/crc32_byte.sv
// One-byte step of the reflected CRC-32 (LSB first), shared by RX checker and TX framer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module crc32_byte
    import gmii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Shift the eight data bits through the LFSR, least significant bit first
    always_comb begin
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_rx_interface.sv
// GMII receive deframer: strips preamble/SFD, writes payload+FCS to the RX FIFO, posts one status word per frame.
// Latency: a byte on the pins reaches fifo_wr/fifo_data 2 cycles later; status follows the en=0 edge by 2 cycles.
// Backpressure: fifo_full drops the byte (err[1]); a pending status word forces the next frame to be dropped whole.
// Optional FCS check built when GMII_RX_FCS_CHECK_EN is defined; otherwise err[3] is tied low.
module gmii_rx_interface
    import gmii_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       gmii_rx_data,
    input  logic             gmii_rx_en,
    input  logic             gmii_rx_er,
    output logic             fifo_wr,
    output logic [7:0]       fifo_data,
    input  logic             fifo_full,
    output logic             status_valid,
    output logic [LEN_W-1:0] status_len,
    output logic [3:0]       status_err,
    input  logic             status_ack,
    output logic [7:0]       drop_count
);

    localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

    logic [7:0]       data_q;
    logic             en_q;
    logic             er_q;

    rx_state_t        state_q;
    rx_state_t        state_d;

    logic [LEN_W-1:0] count_q;
    logic [2:0]       flags_q;     // err[2:0] accumulated over the current frame

    logic             frame_clr;   // SFD seen: start a new frame
    logic             byte_rx;     // a post-SFD byte is being consumed this cycle
    logic             frame_end;   // first en=0 in DATA
    logic             drop_hit;    // a frame is being discarded whole
    logic             at_max;
    logic             wr_ok;
    logic             fcs_bad;

    // Register the GMII pins once; every decision below uses these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= 8'h00;
            en_q   <= 1'b0;
            er_q   <= 1'b0;
        end else begin
            data_q <= gmii_rx_data;
            en_q   <= gmii_rx_en;
            er_q   <= gmii_rx_er;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        state_d   = state_q;
        frame_clr = 1'b0;
        byte_rx   = 1'b0;
        frame_end = 1'b0;
        drop_hit  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_q) begin
                    if (data_q == PREAMBLE_BYTE && !status_valid) begin
                        state_d = ST_PREAMBLE;
                    end else begin
                        // Either a bad first byte or no room to post another status word
                        state_d  = ST_DROP;
                        drop_hit = 1'b1;
                    end
                end
            end
            ST_PREAMBLE: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end else if (data_q == PREAMBLE_BYTE) begin
                    state_d = ST_PREAMBLE;
                end else if (data_q == SFD_BYTE) begin
                    state_d   = ST_DATA;
                    frame_clr = 1'b1;
                end else begin
                    state_d  = ST_DROP;
                    drop_hit = 1'b1;
                end
            end
            ST_DATA: begin
                if (en_q) begin
                    byte_rx = 1'b1;
                end else begin
                    frame_end = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (!en_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Length cap takes precedence over FIFO-full so an oversize frame never reports byte loss for the tail
    assign at_max = (count_q == MAX_CNT);
    assign wr_ok  = byte_rx && !at_max && !fifo_full;

    // Registered FIFO write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr   <= 1'b0;
            fifo_data <= 8'h00;
        end else begin
            fifo_wr <= wr_ok;
            if (wr_ok) begin
                fifo_data <= data_q;
            end
        end
    end

    // Per-frame byte counter and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            flags_q <= 3'b000;
        end else if (frame_clr) begin
            count_q <= '0;
            flags_q <= 3'b000;
        end else if (byte_rx) begin
            if (er_q) begin
                flags_q[ERR_RX_ER] <= 1'b1;
            end
            if (at_max) begin
                flags_q[ERR_OVER] <= 1'b1;
            end else if (fifo_full) begin
                flags_q[ERR_FULL] <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end
    end

`ifdef GMII_RX_FCS_CHECK_EN
    logic [31:0] crc_q;
    logic [31:0] crc_next;
    logic [2:0]  rx_cnt_q;      // received bytes, saturating at 4, for the short-frame check

    crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (data_q),
        .crc_out (crc_next)
    );

    // CRC runs over every received post-SFD byte, whether or not it made it into the FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q    <= CRC_INIT;
            rx_cnt_q <= 3'd0;
        end else if (frame_clr) begin
            crc_q    <= CRC_INIT;
            rx_cnt_q <= 3'd0;
        end else if (byte_rx) begin
            crc_q <= crc_next;
            if (rx_cnt_q != 3'd4) begin
                rx_cnt_q <= rx_cnt_q + 3'd1;
            end
        end
    end

    assign fcs_bad = (crc_q != CRC_RESIDUE) || (rx_cnt_q < 3'd4);
`else
    assign fcs_bad = 1'b0;
`endif

    // Status word: a frame ending wins over an ack arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_valid <= 1'b0;
            status_len   <= '0;
            status_err   <= 4'b0000;
        end else if (frame_end) begin
            status_valid <= 1'b1;
            status_len   <= count_q;
            status_err   <= {fcs_bad, flags_q};
        end else if (status_ack) begin
            status_valid <= 1'b0;
        end
    end

    // Saturating count of frames discarded whole
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'h00;
        end else if (drop_hit && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'h01;
        end
    end

endmodule

// File: tb/tb_gmii_rx_interface.sv
// Randomized self-checking bench for gmii_rx_interface against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: fifo_full is scheduled per received byte; status_ack driven explicitly.
module tb_gmii_rx_interface;

    localparam int MAX_LEN = 1518;
    localparam int LEN_W   = 11;
`ifdef GMII_RX_FCS_CHECK_EN
    localparam bit FCS_EN = 1'b1;
`else
    localparam bit FCS_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0]       gmii_rx_data = 8'h00;
    logic             gmii_rx_en = 1'b0;
    logic             gmii_rx_er = 1'b0;
    logic             fifo_wr;
    logic [7:0]       fifo_data;
    logic             fifo_full = 1'b0;
    logic             status_valid;
    logic [LEN_W-1:0] status_len;
    logic [3:0]       status_err;
    logic             status_ack = 1'b0;
    logic [7:0]       drop_count;

    always #5 clk = ~clk;

    gmii_rx_interface #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gmii_rx_data (gmii_rx_data),
        .gmii_rx_en   (gmii_rx_en),
        .gmii_rx_er   (gmii_rx_er),
        .fifo_wr      (fifo_wr),
        .fifo_data    (fifo_data),
        .fifo_full    (fifo_full),
        .status_valid (status_valid),
        .status_len   (status_len),
        .status_err   (status_err),
        .status_ack   (status_ack),
        .drop_count   (drop_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Everything the DUT writes to the FIFO
    logic [7:0] got_q[$];
    always @(negedge clk) begin
        if (fifo_wr) got_q.push_back(fifo_data);
    end

    // Current frame on the wire: bytes, per-byte fifo_full and rx_er
    logic [7:0] tx_bytes[$];
    bit         tx_full[$];
    bit         tx_er[$];
    bit         fcs_ok;
    int         exp_drop = 0;
    int         last_len;
    int         last_err;

    function automatic logic [31:0] crc_of(input int from);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = from; i < tx_bytes.size(); i++) begin
            logic [7:0] b = tx_bytes[i];
            for (int k = 0; k < 8; k++) begin
                if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
            end
        end
        return c;
    endfunction

    // Preamble + SFD + n random payload bytes, optionally followed by a correct FCS
    task automatic build(input int n, input bit good);
        logic [31:0] fcs;
        tx_bytes.delete(); tx_full.delete(); tx_er.delete();
        repeat (7) tx_bytes.push_back(8'h55);
        tx_bytes.push_back(8'hD5);
        for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom));
        if (good) begin
            fcs = ~crc_of(8);
            for (int i = 0; i < 4; i++) tx_bytes.push_back(fcs[8*i +: 8]);
        end
        fcs_ok = good;
        foreach (tx_bytes[i]) begin
            tx_full.push_back(1'b0);
            tx_er.push_back(1'b0);
        end
    endtask

    // fifo_full for byte k is presented one cycle after byte k, matching the input register
    task automatic drive();
        int n = tx_bytes.size();
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            gmii_rx_en   = 1'b1;
            gmii_rx_data = tx_bytes[k];
            gmii_rx_er   = tx_er[k];
            fifo_full    = (k > 0) ? tx_full[k-1] : 1'b0;
        end
        @(posedge clk); #1;
        gmii_rx_en   = 1'b0;
        gmii_rx_data = 8'h00;
        gmii_rx_er   = 1'b0;
        fifo_full    = (n > 0) ? tx_full[n-1] : 1'b0;
        @(posedge clk); #1;
        fifo_full    = 1'b0;
    endtask

    // Reference: walk post-SFD bytes, apply the cap, then FIFO-full, then write
    task automatic expect_frame(input string tag);
        logic [7:0] exp_q[$];
        int cnt = 0;
        int bad = 0;
        int w = 0;
        bit e0 = 0, e1 = 0, e2 = 0, e3;
        for (int i = 8; i < tx_bytes.size(); i++) begin
            if (tx_er[i]) e0 = 1;
            if (cnt == MAX_LEN)  e2 = 1;
            else if (tx_full[i]) e1 = 1;
            else begin exp_q.push_back(tx_bytes[i]); cnt++; end
        end
        e3 = FCS_EN && !fcs_ok;
        last_len = cnt;
        last_err = {28'd0, e3, e2, e1, e0};
        while (!status_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, ":valid"}, status_valid, 1);
        check({tag, ":len"}, status_len, last_len);
        check({tag, ":err"}, status_err, last_err);
        check({tag, ":nwr"}, got_q.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        end
        check({tag, ":bytes"}, bad, 0);
    endtask

    task automatic ack(input string tag);
        @(posedge clk); #1;
        status_ack = 1'b1;
        @(posedge clk); #1;
        status_ack = 1'b0;
        check({tag, ":ackclr"}, status_valid, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":fifo_wr"}, fifo_wr, 0);
        check({tag, ":fifo_data"}, fifo_data, 0);
        check({tag, ":valid"}, status_valid, 0);
        check({tag, ":len"}, status_len, 0);
        check({tag, ":err"}, status_err, 0);
        check({tag, ":drop"}, drop_count, 0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #20;
        check_reset_vals("rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Good 64-byte frame
        got_q.delete(); build(60, 1); drive(); expect_frame("good");
        check("good:len64", status_len, 64);
        ack("good");

        // Corrupted payload bit, FCS left as computed for the clean frame
        got_q.delete(); build(60, 1); tx_bytes[20] ^= 8'h04; fcs_ok = 0;
        drive(); expect_frame("badfcs"); ack("badfcs");

        // Three cycles of fifo_full mid-payload
        got_q.delete(); build(60, 1);
        for (int i = 30; i < 33; i++) tx_full[i] = 1'b1;
        drive(); expect_frame("bp");
        check("bp:len61", status_len, 61);
        ack("bp");

        // 1600 bytes after SFD
        got_q.delete(); build(1600, 0); drive(); expect_frame("over");
        check("over:len", status_len, MAX_LEN);
        ack("over");

        // SFD immediately followed by en=0
        got_q.delete(); build(0, 0); drive(); expect_frame("zero"); ack("zero");

        // Status held: second frame must be dropped whole without disturbing the first status
        got_q.delete(); build(40, 1); drive(); expect_frame("held_a");
        got_q.delete(); build(40, 1); drive();
        exp_drop++;
        repeat (3) @(posedge clk); #1;
        check("held:nwr", got_q.size(), 0);
        check("held:drop", drop_count, exp_drop);
        check("held:valid", status_valid, 1);
        check("held:len", status_len, last_len);
        check("held:err", status_err, last_err);
        ack("held");

        // Bad preamble 55 55 12
        got_q.delete();
        tx_bytes.delete(); tx_full.delete(); tx_er.delete();
        tx_bytes = '{8'h55, 8'h55, 8'h12};
        tx_full  = '{0, 0, 0};
        tx_er    = '{0, 0, 0};
        drive();
        exp_drop++;
        repeat (3) @(posedge clk); #1;
        check("badpre:nwr", got_q.size(), 0);
        check("badpre:drop", drop_count, exp_drop);
        check("badpre:valid", status_valid, 0);

        // Randomized frames with occasional backpressure, rx_er and bad FCS
        for (int f = 0; f < 25; f++) begin
            got_q.delete();
            build($urandom_range(0, 80), $urandom_range(0, 3) != 0);
            for (int i = 8; i < tx_bytes.size(); i++) begin
                tx_full[i] = ($urandom_range(0, 9) == 0);
                tx_er[i]   = ($urandom_range(0, 19) == 0);
            end
            drive();
            expect_frame($sformatf("rnd%0d", f));
            ack($sformatf("rnd%0d", f));
            repeat ($urandom_range(1, 4)) @(posedge clk);
        end

        // Asynchronous reset in the middle of DATA
        got_q.delete(); build(60, 1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            gmii_rx_en   = 1'b1;
            gmii_rx_data = tx_bytes[k];
        end
        #3 rst_n = 1'b0;
        #1;
        exp_drop = 0;
        check_reset_vals("midrst");
        gmii_rx_en = 1'b0;
        gmii_rx_data = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        got_q.delete(); build(60, 1); drive(); expect_frame("postrst"); ack("postrst");

        // drop_count saturation
        for (int i = 0; i < 260; i++) begin
            @(posedge clk); #1;
            gmii_rx_en = 1'b1; gmii_rx_data = 8'h12;
            @(posedge clk); #1;
            gmii_rx_en = 1'b0; gmii_rx_data = 8'h00;
        end
        exp_drop = (exp_drop + 260 > 255) ? 255 : exp_drop + 260;
        repeat (3) @(posedge clk); #1;
        check("sat:drop", drop_count, exp_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
